// File: rtl/ebox_pkg.sv
// Shared EBOX/MBOX types: mailbox arbiter state encoding and default build parameters.
package ebox_pkg;

  localparam int MBOX_NCHAN   = 8;
  localparam int MBOX_PAW     = 22;
  localparam int MBOX_DW      = 36;
  localparam int MBOX_TIMEOUT = 63;
  localparam int MBOX_TMO_W   = 8;

  typedef enum logic [1:0] {
    MBOX_IDLE = 2'd0,
    MBOX_REQ  = 2'd1,
    MBOX_WAIT = 2'd2
  } mboxState_t;

endpackage

// File: rtl/mbox_rr_pick.sv
// Round-robin pick: first set bit of req at or after ptr, wrapping to bit 0; one-hot result.
module mbox_rr_pick #(
  parameter int W  = 8,
  parameter int PW = $clog2(W + 1)
) (
  input  logic [W-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [W-1:0]  gnt
);

  logic [W-1:0] atOrAfter;
  logic [W-1:0] masked;

  // A pointer at or past W leaves the mask empty, so the pick falls back to the lowest requester.
  assign atOrAfter = ~((W'(1) << ptr) - W'(1));
  assign masked    = req & atOrAfter;
  assign gnt       = (|masked) ? (masked & (~masked + W'(1))) : (req & (~req + W'(1)));

endmodule

// File: rtl/mbox_req_arb.sv
// MBOX request arbiter: grants one of EBOX/channels, runs a single memory transaction,
// and returns Done (or Done+Nxm on timeout) to the owner.
module mbox_req_arb
  import ebox_pkg::*;
#(
  parameter int NCHAN   = MBOX_NCHAN,
  parameter int PAW     = MBOX_PAW,
  parameter int DW      = MBOX_DW,
  parameter int TIMEOUT = MBOX_TIMEOUT
) (
  input  logic                mboxClk,
  input  logic                mboxReset,
  input  logic                prioMode,
  input  logic                ebxReq,
  input  logic                ebxWrite,
  input  logic [PAW-1:0]      ebxAddr,
  input  logic [DW-1:0]       ebxWdata,
  output logic                ebxGnt,
  output logic                ebxDone,
  output logic                ebxNxm,
  input  logic [NCHAN-1:0]    chReq,
  input  logic [NCHAN-1:0]    chWrite,
  input  logic [NCHAN*PAW-1:0] chAddr,
  input  logic [NCHAN*DW-1:0] chWdata,
  output logic [NCHAN-1:0]    chGnt,
  output logic [NCHAN-1:0]    chDone,
  output logic [NCHAN-1:0]    chNxm,
  output logic [DW-1:0]       rdata,
  output logic                memReq,
  output logic                memWrite,
  output logic [PAW-1:0]      memAddr,
  output logic [DW-1:0]       memWdata,
  input  logic                memAck,
  input  logic                memRdv,
  input  logic [DW-1:0]       memRdata
);

  localparam int NSLOT = NCHAN + 1;
  localparam int PTRW  = $clog2(NSLOT);

  mboxState_t state, nextState;

  logic [PTRW-1:0]       rrPtr, owner, winIdx, nextPtr;
  logic [MBOX_TMO_W-1:0] tmoCnt;
  logic [PAW-1:0]        latAddr, selAddr;
  logic [DW-1:0]         latWdata, selWdata;
  logic                  latWrite, selWrite;
  logic [NCHAN-1:0]      chPickGnt;
  logic [NCHAN:0]        ringGnt, winOh;
  logic                  anyReq, startTxn, rdvHit, tmoHit, finish;

  // Slot NCHAN of the ring is the EBOX; the channel-only picker serves fixed-priority mode.
  mbox_rr_pick #(.W(NCHAN), .PW(PTRW)) uChPick (
    .req(chReq),
    .ptr(rrPtr),
    .gnt(chPickGnt)
  );

  mbox_rr_pick #(.W(NSLOT), .PW(PTRW)) uRingPick (
    .req({ebxReq, chReq}),
    .ptr(rrPtr),
    .gnt(ringGnt)
  );

  assign anyReq   = ebxReq | (|chReq);
  assign winOh    = prioMode ? ringGnt : (ebxReq ? {1'b1, {NCHAN{1'b0}}} : {1'b0, chPickGnt});
  assign startTxn = (state == MBOX_IDLE) && anyReq;
  assign rdvHit   = memRdv && ((state == MBOX_WAIT) || ((state == MBOX_REQ) && memAck));
  assign tmoHit   = (state != MBOX_IDLE) && (tmoCnt == MBOX_TMO_W'(TIMEOUT)) && !rdvHit;
  assign finish   = rdvHit || tmoHit;

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    winIdx   = '0;
    selAddr  = ebxAddr;
    selWdata = ebxWdata;
    selWrite = ebxWrite;
    for (int i = 0; i < NCHAN; i++) begin
      if (winOh[i]) begin
        winIdx   = PTRW'(i);
        selAddr  = chAddr[i*PAW +: PAW];
        selWdata = chWdata[i*DW +: DW];
        selWrite = chWrite[i];
      end
    end
    if (winOh[NCHAN]) winIdx = PTRW'(NCHAN);
  end

  // Fixed-priority EBOX grants leave the channel rotation untouched.
  always_comb begin
    if (!prioMode && winOh[NCHAN]) nextPtr = rrPtr;
    else if (winIdx == PTRW'(prioMode ? NCHAN : NCHAN - 1)) nextPtr = '0;
    else nextPtr = winIdx + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge mboxClk) begin
    if (mboxReset) state <= MBOX_IDLE;
    else           state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      MBOX_IDLE: if (anyReq) nextState = MBOX_REQ;
      MBOX_REQ: begin
        if (finish)      nextState = MBOX_IDLE;
        else if (memAck) nextState = MBOX_WAIT;
      end
      MBOX_WAIT: if (finish) nextState = MBOX_IDLE;
      default:   nextState = MBOX_IDLE;
    endcase
  end

  // NOTE: the latched request fields are plain registers (not memory), so they are reset to keep outputs clean.
  always_ff @(posedge mboxClk) begin
    if (mboxReset) begin
      rrPtr    <= '0;
      owner    <= '0;
      tmoCnt   <= '0;
      latAddr  <= '0;
      latWdata <= '0;
      latWrite <= 1'b0;
    end else if (startTxn) begin
      rrPtr    <= nextPtr;
      owner    <= winIdx;
      tmoCnt   <= '0;
      latAddr  <= selAddr;
      latWdata <= selWdata;
      latWrite <= selWrite;
    end else if (state != MBOX_IDLE) begin
      tmoCnt <= tmoCnt + 1'b1;
    end
  end

  // All outputs are forced low while reset is asserted, even mid-transaction.
  always_comb begin
    ebxGnt   = 1'b0;
    ebxDone  = 1'b0;
    ebxNxm   = 1'b0;
    chGnt    = '0;
    chDone   = '0;
    chNxm    = '0;
    rdata    = '0;
    memReq   = 1'b0;
    memWrite = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    if (!mboxReset) begin
      if (startTxn) begin
        ebxGnt = winOh[NCHAN];
        chGnt  = winOh[NCHAN-1:0];
      end
      memReq   = (state == MBOX_REQ) && !tmoHit;
      memWrite = memReq && latWrite;
      memAddr  = latAddr;
      memWdata = latWdata;
      if (rdvHit) rdata = memRdata;
      for (int i = 0; i < NCHAN; i++) begin
        chDone[i] = finish && (owner == PTRW'(i));
        chNxm[i]  = tmoHit && (owner == PTRW'(i));
      end
      ebxDone = finish && (owner == PTRW'(NCHAN));
      ebxNxm  = tmoHit && (owner == PTRW'(NCHAN));
    end
  end

endmodule
